// File: rtl/axil_cmd_master.sv
// AXI4-Lite initiator: each command beat from the stream becomes one single-beat read or write,
// and each finished (or timed-out) transaction returns one response beat.
module axil_cmd_master #(
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_DATA_WIDTH = 32,
    parameter int C_TIMEOUT    = 256
) (
    input  logic                      s_axi_aclk,
    input  logic                      s_axi_aresetn,
    output logic                      s_axis_cmd_tready,
    input  logic                      s_axis_cmd_tvalid,
    input  logic                      s_axis_cmd_op,
    input  logic [C_ADDR_WIDTH-1:0]   s_axis_cmd_addr,
    input  logic [C_DATA_WIDTH-1:0]   s_axis_cmd_wdata,
    input  logic [C_DATA_WIDTH/8-1:0] s_axis_cmd_wstrb,
    input  logic                      m_axis_rsp_tready,
    output logic                      m_axis_rsp_tvalid,
    output logic                      m_axis_rsp_op,
    output logic [C_DATA_WIDTH-1:0]   m_axis_rsp_rdata,
    output logic [1:0]                m_axis_rsp_resp,
    output logic                      m_axis_rsp_tout,
    output logic [C_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [C_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [C_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [C_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    output logic [2:0]                dbg_state_o
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_REQ  = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD_REQ  = 3'd3;
    localparam logic [2:0] S_RD_DATA = 3'd4;
    localparam logic [2:0] S_RSP     = 3'd5;

    localparam int          CW      = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT) : 1;
    localparam int          TO_LAST = (C_TIMEOUT > 0) ? C_TIMEOUT - 1 : 0;
    localparam bit          TO_EN   = (C_TIMEOUT != 0);
    localparam logic [CW-1:0] TO_LAST_C = CW'(TO_LAST);

    logic [2:0]                state_q, state_d;
    logic                      cmd_tready_q, cmd_tready_d;
    logic [C_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [C_DATA_WIDTH-1:0]   wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
    logic [C_DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic                      awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                      arvalid_q, arvalid_d, rready_q, rready_d;
    logic                      aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                      rsp_tvalid_q, rsp_tvalid_d, rsp_op_q, rsp_op_d, rsp_tout_q, rsp_tout_d;
    logic [1:0]                rsp_resp_q, rsp_resp_d;
    logic [CW-1:0]             tmo_q, tmo_d;

    logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs, tmo_hit, abort;

    // A beat transfers on a clock edge where valid and ready are both high; every valid/ready
    // driven here is a register, and a valid is held until its handshake (timeout/reset excepted).
    assign cmd_hs  = s_axis_cmd_tvalid & cmd_tready_q;
    assign aw_hs   = awvalid_q & m_axi_awready;
    assign w_hs    = wvalid_q & m_axi_wready;
    assign b_hs    = bready_q & m_axi_bvalid;
    assign ar_hs   = arvalid_q & m_axi_arready;
    assign r_hs    = rready_q & m_axi_rvalid;
    assign rsp_hs  = rsp_tvalid_q & m_axis_rsp_tready;
    assign tmo_hit = TO_EN && (tmo_q == TO_LAST_C);

    always_comb begin
        state_d     = state_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_tvalid_d = rsp_tvalid_q;
        rsp_op_d    = rsp_op_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_tout_d  = rsp_tout_q;
        tmo_d       = tmo_q;
        abort       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_hs) begin
                    rsp_op_d = s_axis_cmd_op;
                    tmo_d    = '0;
                    if (s_axis_cmd_op) begin
                        araddr_d  = s_axis_cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = S_RD_REQ;
                    end else begin
                        awaddr_d  = s_axis_cmd_addr;
                        wdata_d   = s_axis_cmd_wdata;
                        wstrb_d   = s_axis_cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = S_WR_REQ;
                    end
                end
            end
            S_WR_REQ: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs)  wvalid_d  = 1'b0;
                if (aw_done_d && w_done_d) begin
                    bready_d = 1'b1;
                    tmo_d    = '0;
                    state_d  = S_WR_RESP;
                end else if (aw_hs || w_hs) begin
                    tmo_d = '0;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end else begin
                    tmo_d = tmo_q + CW'(1);
                end
            end
            S_WR_RESP: begin
                if (b_hs) begin
                    bready_d     = 1'b0;
                    rsp_resp_d   = m_axi_bresp;
                    rsp_rdata_d  = '0;
                    rsp_tout_d   = 1'b0;
                    rsp_tvalid_d = 1'b1;
                    state_d      = S_RSP;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end else begin
                    tmo_d = tmo_q + CW'(1);
                end
            end
            S_RD_REQ: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    tmo_d     = '0;
                    state_d   = S_RD_DATA;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end else begin
                    tmo_d = tmo_q + CW'(1);
                end
            end
            S_RD_DATA: begin
                // rready is raised one cycle after entering, giving the read path its extra cycle.
                rready_d = 1'b1;
                if (r_hs) begin
                    rready_d     = 1'b0;
                    rsp_resp_d   = m_axi_rresp;
                    rsp_rdata_d  = m_axi_rdata;
                    rsp_tout_d   = 1'b0;
                    rsp_tvalid_d = 1'b1;
                    state_d      = S_RSP;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end else begin
                    tmo_d = tmo_q + CW'(1);
                end
            end
            S_RSP: begin
                if (rsp_hs) begin
                    rsp_tvalid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Debug recovery: abandons the slave mid-protocol and reports a synthetic SLVERR.
        if (abort) begin
            awvalid_d    = 1'b0;
            wvalid_d     = 1'b0;
            bready_d     = 1'b0;
            arvalid_d    = 1'b0;
            rready_d     = 1'b0;
            rsp_resp_d   = 2'b10;
            rsp_tout_d   = 1'b1;
            rsp_rdata_d  = '0;
            rsp_tvalid_d = 1'b1;
            state_d      = S_RSP;
        end
        cmd_tready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q      <= S_IDLE;
            cmd_tready_q <= 1'b0;
            awaddr_q     <= '0;
            araddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            rsp_tvalid_q <= 1'b0;
            rsp_op_q     <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_resp_q   <= 2'b00;
            rsp_tout_q   <= 1'b0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            cmd_tready_q <= cmd_tready_d;
            awaddr_q     <= awaddr_d;
            araddr_q     <= araddr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            rsp_tvalid_q <= rsp_tvalid_d;
            rsp_op_q     <= rsp_op_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_resp_q   <= rsp_resp_d;
            rsp_tout_q   <= rsp_tout_d;
            tmo_q        <= tmo_d;
        end
    end

    assign s_axis_cmd_tready = cmd_tready_q;
    assign m_axis_rsp_tvalid = rsp_tvalid_q;
    assign m_axis_rsp_op     = rsp_op_q;
    assign m_axis_rsp_rdata  = rsp_rdata_q;
    assign m_axis_rsp_resp   = rsp_resp_q;
    assign m_axis_rsp_tout   = rsp_tout_q;
    assign m_axi_awaddr      = awaddr_q;
    assign m_axi_awprot      = 3'b000;
    assign m_axi_awvalid     = awvalid_q;
    assign m_axi_wdata       = wdata_q;
    assign m_axi_wstrb       = wstrb_q;
    assign m_axi_wvalid      = wvalid_q;
    assign m_axi_bready      = bready_q;
    assign m_axi_araddr      = araddr_q;
    assign m_axi_arprot      = 3'b000;
    assign m_axi_arvalid     = arvalid_q;
    assign m_axi_rready      = rready_q;
    assign dbg_state_o       = state_q;
endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master: a small AXI4-Lite memory slave with programmable ready
// delays, a posedge monitor for handshake counts/latency, and hand-computed expectations.
module tb_axil_cmd_master;
    logic        clk = 1'b0;
    logic        aresetn;
    logic        cmd_tready, cmd_tvalid, cmd_op;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_tready, rsp_tvalid, rsp_op, rsp_tout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot, dbg_state;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axil_cmd_master #(.C_ADDR_WIDTH(32), .C_DATA_WIDTH(32), .C_TIMEOUT(16)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(aresetn),
        .s_axis_cmd_tready(cmd_tready), .s_axis_cmd_tvalid(cmd_tvalid), .s_axis_cmd_op(cmd_op),
        .s_axis_cmd_addr(cmd_addr), .s_axis_cmd_wdata(cmd_wdata), .s_axis_cmd_wstrb(cmd_wstrb),
        .m_axis_rsp_tready(rsp_tready), .m_axis_rsp_tvalid(rsp_tvalid), .m_axis_rsp_op(rsp_op),
        .m_axis_rsp_rdata(rsp_rdata), .m_axis_rsp_resp(rsp_resp), .m_axis_rsp_tout(rsp_tout),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .dbg_state_o(dbg_state)
    );

    logic [10:0] ctrl_vec;
    logic        any_data;
    assign ctrl_vec = {cmd_tready, rsp_tvalid, awvalid, wvalid, bready, arvalid, rready,
                       rsp_op, rsp_tout, rsp_resp};
    assign any_data = |{awaddr, wdata, wstrb, araddr, rsp_rdata, awprot, arprot};

    // ---------------- slave model ----------------
    int          aw_dly, w_dly, aw_cnt, w_cnt;
    logic        ar_en;
    logic [1:0]  sl_bresp;
    logic [31:0] mem [0:15];
    logic        aw_got, w_got, ag, wg;
    logic [31:0] sl_addr, sl_data, a_t, d_t;
    logic [3:0]  sl_strb, s_t;

    assign awready = awvalid && (aw_cnt >= aw_dly);
    assign wready  = wvalid && (w_cnt >= w_dly);
    assign arready = arvalid && ar_en;

    initial for (int i = 0; i < 16; i++) mem[i] = 32'h0;

    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rdata <= 32'h0; rresp <= 2'b00;
            sl_addr <= 32'h0; sl_data <= 32'h0; sl_strb <= 4'h0;
        end else begin
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
            ag  = aw_got || (awvalid && awready);
            wg  = w_got || (wvalid && wready);
            a_t = (awvalid && awready) ? awaddr : sl_addr;
            d_t = (wvalid && wready) ? wdata : sl_data;
            s_t = (wvalid && wready) ? wstrb : sl_strb;
            if (bvalid && bready) bvalid <= 1'b0;
            if (ag && wg) begin
                for (int i = 0; i < 4; i++)
                    if (s_t[i]) mem[a_t[5:2]][8*i +: 8] <= d_t[8*i +: 8];
                bvalid <= 1'b1;
                bresp  <= sl_bresp;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else begin
                aw_got <= ag; w_got <= wg;
                sl_addr <= a_t; sl_data <= d_t; sl_strb <= s_t;
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rdata  <= mem[araddr[5:2]];
                rresp  <= 2'b00;
            end
        end
    end

    // ---------------- monitor ----------------
    int cyc = 0, acc_cyc = 0, rsp_first = 0, rsp_hs_cyc = 0, ar_vcnt = 0;
    int n_acc = 0, n_aw = 0, n_w = 0, n_ar = 0, n_rsp = 0;
    int n_early = 0, n_busy = 0, n_unst = 0;
    logic        rsp_seen = 1'b0, aw_seen = 1'b0, w_seen = 1'b0, outstanding = 1'b0, hold_prev = 1'b0;
    logic [31:0] last_awaddr = 0, last_wdata = 0, last_araddr = 0;
    logic [3:0]  last_wstrb = 0;
    logic [35:0] prev_rsp = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!aresetn) begin
            outstanding <= 1'b0;
            hold_prev   <= 1'b0;
        end else begin
            if (cmd_tvalid && cmd_tready) begin
                n_acc <= n_acc + 1; acc_cyc <= cyc; rsp_seen <= 1'b0; ar_vcnt <= 0;
                aw_seen <= 1'b0; w_seen <= 1'b0; outstanding <= 1'b1;
            end
            if (arvalid) ar_vcnt <= ar_vcnt + 1;
            if (awvalid && awready) begin n_aw <= n_aw + 1; last_awaddr <= awaddr; aw_seen <= 1'b1; end
            if (wvalid && wready) begin n_w <= n_w + 1; last_wdata <= wdata; last_wstrb <= wstrb; w_seen <= 1'b1; end
            if (arvalid && arready) begin n_ar <= n_ar + 1; last_araddr <= araddr; end
            if (bready && !(aw_seen && w_seen)) n_early <= n_early + 1;
            if (rsp_tvalid && !rsp_seen) begin rsp_first <= cyc; rsp_seen <= 1'b1; end
            if (rsp_tvalid && rsp_tready) begin n_rsp <= n_rsp + 1; rsp_hs_cyc <= cyc; outstanding <= 1'b0; end
            if (cmd_tready && outstanding) n_busy <= n_busy + 1;
            if (hold_prev && (!rsp_tvalid || {rsp_op, rsp_tout, rsp_resp, rsp_rdata} != prev_rsp))
                n_unst <= n_unst + 1;
            hold_prev <= rsp_tvalid && !rsp_tready;
            prev_rsp  <= {rsp_op, rsp_tout, rsp_resp, rsp_rdata};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic op, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] st);
        int n = 0;
        @(negedge clk);
        cmd_op = op; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = st; cmd_tvalid = 1'b1;
        while (!cmd_tready && n < 50) begin @(negedge clk); n++; end
        chk("cmd_accepted", (n < 50), 1);
        @(negedge clk);
        cmd_tvalid = 1'b0;
    endtask

    task automatic wait_rsp(output logic op, output logic [31:0] rd, output logic [1:0] rs,
                            output logic to);
        int n = 0;
        while (!rsp_tvalid && n < 60) begin @(negedge clk); n++; end
        chk("rsp_arrived", (n < 60), 1);
        op = rsp_op; rd = rsp_rdata; rs = rsp_resp; to = rsp_tout;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic        r_op, r_to;
        logic [31:0] r_rd;
        logic [1:0]  r_rs;
        int b_aw, b_w, b_ar, b_e, b_busy, b_unst, b_acc, b_rsp;
        int aw_tab [3] = '{5, 1, 2};
        int w_tab  [3] = '{1, 5, 2};
        logic [35:0] f0;

        aresetn = 1'b0; cmd_tvalid = 1'b0; cmd_op = 1'b0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_tready = 1'b0; aw_dly = 0; w_dly = 0; ar_en = 1'b1; sl_bresp = 2'b00;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", ctrl_vec, 0);
        chk("reset_data", any_data, 0);
        chk("reset_state", dbg_state, 0);
        aresetn = 1'b1;
        @(negedge clk);
        chk("idle_tready", cmd_tready, 1);
        rsp_tready = 1'b1;

        // 1: zero-wait write
        b_aw = n_aw; b_w = n_w;
        send_cmd(1'b0, 32'h4, 32'hDEADBEEF, 4'hF);
        wait_rsp(r_op, r_rd, r_rs, r_to);
        chk("wr_aw_count", n_aw - b_aw, 1);
        chk("wr_w_count", n_w - b_w, 1);
        chk("wr_awaddr", last_awaddr, 32'h4);
        chk("wr_wdata", last_wdata, 32'hDEADBEEF);
        chk("wr_wstrb", last_wstrb, 4'hF);
        chk("wr_awprot", awprot, 0);
        chk("wr_rsp", {r_op, r_to, r_rs, r_rd}, 0);
        chk("wr_latency", rsp_first - acc_cyc, 3);

        // 2: zero-wait read back
        send_cmd(1'b1, 32'h4, 32'h0, 4'h0);
        wait_rsp(r_op, r_rd, r_rs, r_to);
        chk("rd_araddr", last_araddr, 32'h4);
        chk("rd_arprot", arprot, 0);
        chk("rd_op", r_op, 1);
        chk("rd_rdata", r_rd, 32'hDEADBEEF);
        chk("rd_resp_tout", {r_to, r_rs}, 0);
        chk("rd_latency", rsp_first - acc_cyc, 4);

        // 3: staggered aw/w readiness
        for (int i = 0; i < 3; i++) begin
            aw_dly = aw_tab[i]; w_dly = w_tab[i];
            b_aw = n_aw; b_w = n_w; b_e = n_early;
            send_cmd(1'b0, 32'h8 + 32'(4 * i), 32'h11111111 * 32'(i + 1), 4'hF);
            wait_rsp(r_op, r_rd, r_rs, r_to);
            chk("stag_aw_once", n_aw - b_aw, 1);
            chk("stag_w_once", n_w - b_w, 1);
            chk("stag_bready_early", n_early - b_e, 0);
            chk("stag_rsp", {r_op, r_to, r_rs}, 0);
        end
        aw_dly = 0; w_dly = 0;
        send_cmd(1'b0, 32'h8, 32'hABCDEF01, 4'b0101);
        wait_rsp(r_op, r_rd, r_rs, r_to);
        send_cmd(1'b1, 32'h8, 32'h0, 4'h0);
        wait_rsp(r_op, r_rd, r_rs, r_to);
        chk("strobe_merge", r_rd, 32'h11CD1101);
        sl_bresp = 2'b11;
        send_cmd(1'b0, 32'h14, 32'h5, 4'hF);
        wait_rsp(r_op, r_rd, r_rs, r_to);
        chk("bresp_passthru", {r_to, r_rs}, 3'b011);
        sl_bresp = 2'b00;

        // 4: back-to-back commands under response backpressure
        rsp_tready = 1'b0;
        b_aw = n_aw; b_ar = n_ar; b_busy = n_busy; b_unst = n_unst; b_acc = n_acc;
        send_cmd(1'b0, 32'h18, 32'hCAFEF00D, 4'hF);
        cmd_op = 1'b1; cmd_addr = 32'h18; cmd_wdata = 0; cmd_wstrb = 0; cmd_tvalid = 1'b1;
        for (int n = 0; n < 40 && !rsp_tvalid; n++) @(negedge clk);
        f0 = {rsp_op, rsp_tout, rsp_resp, rsp_rdata};
        repeat (10) @(negedge clk);
        chk("bp_rsp_held", {rsp_tvalid, rsp_op, rsp_tout, rsp_resp, rsp_rdata}, {1'b1, 36'h0});
        chk("bp_fields_first", f0, 0);
        chk("bp_cmd_tready", cmd_tready, 0);
        chk("bp_no_ar", n_ar - b_ar, 0);
        chk("bp_one_aw", n_aw - b_aw, 1);
        chk("bp_tready_busy", n_busy - b_busy, 0);
        chk("bp_unstable", n_unst - b_unst, 0);
        rsp_tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_second_accept", n_acc - b_acc, 2);
        chk("bp_accept_gap", acc_cyc - rsp_hs_cyc, 1);
        cmd_tvalid = 1'b0;
        wait_rsp(r_op, r_rd, r_rs, r_to);
        chk("bp_second_rsp", {r_op, r_to, r_rs, r_rd}, {1'b1, 3'b000, 32'hCAFEF00D});

        // 5: read timeout
        ar_en = 1'b0; b_ar = n_ar;
        send_cmd(1'b1, 32'h1C, 32'h0, 4'h0);
        wait_rsp(r_op, r_rd, r_rs, r_to);
        chk("to_arvalid_cycles", ar_vcnt, 16);
        chk("to_rsp", {r_op, r_to, r_rs, r_rd}, {1'b1, 1'b1, 2'b10, 32'h0});
        chk("to_no_ar_hs", n_ar - b_ar, 0);
        chk("to_arvalid_low", arvalid, 0);
        ar_en = 1'b1;
        send_cmd(1'b1, 32'h4, 32'h0, 4'h0);
        wait_rsp(r_op, r_rd, r_rs, r_to);
        chk("to_recover", {r_op, r_to, r_rs, r_rd}, {1'b1, 3'b000, 32'hDEADBEEF});

        // 6: reset while awvalid is up
        aw_dly = 100; b_rsp = n_rsp; b_aw = n_aw;
        send_cmd(1'b0, 32'h20, 32'h12345678, 4'hF);
        @(negedge clk);
        chk("rst_awvalid_up", awvalid, 1);
        #2 aresetn = 1'b0;
        #1;
        chk("rst_ctrl_async", ctrl_vec, 0);
        chk("rst_data_async", any_data, 0);
        @(negedge clk);
        aresetn = 1'b1; aw_dly = 0;
        @(negedge clk);
        chk("rst_tready_back", cmd_tready, 1);
        repeat (10) @(negedge clk);
        chk("rst_no_rsp", n_rsp - b_rsp, 0);
        chk("rst_no_aw", n_aw - b_aw, 0);
        send_cmd(1'b0, 32'h24, 32'h0BADCAFE, 4'hF);
        wait_rsp(r_op, r_rd, r_rs, r_to);
        chk("rst_wr_after", {r_op, r_to, r_rs, r_rd}, 0);
        send_cmd(1'b1, 32'h24, 32'h0, 4'h0);
        wait_rsp(r_op, r_rd, r_rs, r_to);
        chk("rst_rd_after", r_rd, 32'h0BADCAFE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
